// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit_if
// Description : Memory-side bus between mem_access_unit (master) and the RAM
//               (slave). The master drives the address, strobes and write
//               data. The slave returns read data and a ready flag that
//               completes the current access.
// Signals     : mem_addr  [ADDR_W] master->slave  access address
//               mem_rd    [1]      master->slave  read strobe
//               mem_wr    [1]      master->slave  write strobe
//               mem_wdata [DATA_W] master->slave  write data
//               mem_rdata [DATA_W] slave->master  read data, valid with ready
//               mem_ready [1]      slave->master  access completes this edge
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_access_unit_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport master (
        output mem_addr, mem_rd, mem_wr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_addr, mem_rd, mem_wr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : Program counter, instruction register, data-address register
//               and a wait-state memory sequencer (IDLE/ACCESS/DONE) with a
//               timeout. The controller issues single-cycle requests and
//               waits for done (success) or err (dropped request / timeout).
// Ports       : clk, rst_n (synchronous, active-low)
//               start_pc, clear_pc, pc_cmd, branch_off, branch_abs -> PC
//               load_addr, addr_src                -> data-address register
//               fetch_req, data_rd_req, data_wr_req, wr_data -> requests
//               mem (mem_access_unit_if.master)    -> memory bus
//               pc, pc_plus1, instr, rd_data       -> architectural state
//               busy, done, err                    -> status
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter int OFF_W   = 8,
    parameter int TIMEOUT = 15
) (
    input  wire                clk,
    input  wire                rst_n,
    input  wire  [ADDR_W-1:0]  start_pc,
    input  wire                clear_pc,
    input  wire  [1:0]         pc_cmd,
    input  wire  [OFF_W-1:0]   branch_off,
    input  wire  [ADDR_W-1:0]  branch_abs,
    input  wire                load_addr,
    input  wire  [DATA_W-1:0]  addr_src,
    input  wire                fetch_req,
    input  wire                data_rd_req,
    input  wire                data_wr_req,
    input  wire  [DATA_W-1:0]  wr_data,
    mem_access_unit_if.master  mem,
    output logic [ADDR_W-1:0]  pc,
    output logic [ADDR_W-1:0]  pc_plus1,
    output logic [DATA_W-1:0]  instr,
    output logic [DATA_W-1:0]  rd_data,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int                 c_CNT_W       = $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT_CNT = c_CNT_W'(TIMEOUT);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE     = c_CNT_W'(1);
    localparam logic [ADDR_W-1:0]  c_PC_ONE      = ADDR_W'(1);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_ACCESS = 2'd1;
    localparam logic [1:0] c_ST_DONE   = 2'd2;

    localparam logic [1:0] c_KIND_FETCH = 2'd0;
    localparam logic [1:0] c_KIND_READ  = 2'd1;
    localparam logic [1:0] c_KIND_WRITE = 2'd2;

    logic [1:0]         r_state;
    logic [ADDR_W-1:0]  r_pc;
    logic [ADDR_W-1:0]  r_daddr;
    logic [1:0]         r_kind;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic [c_CNT_W-1:0] r_cnt;
    logic [DATA_W-1:0]  r_instr;
    logic [DATA_W-1:0]  r_rd_data;
    logic               r_done;
    logic               r_err;

    logic [1:0]         w_state_nxt;
    logic               w_accept;
    logic               w_capture;
    logic               w_err_nxt;
    logic [1:0]         w_kind_sel;
    logic               w_req_any;
    logic               w_req_multi;
    logic [ADDR_W-1:0]  w_off_ext;
    logic [ADDR_W-1:0]  w_pc_nxt;
    logic               w_unused_src;

    // Only the low ADDR_W bits of the datapath result form an address.
    assign w_unused_src = ^addr_src;

    assign w_req_any   = fetch_req | data_rd_req | data_wr_req;
    assign w_req_multi = (fetch_req & (data_rd_req | data_wr_req)) | (data_rd_req & data_wr_req);
    assign w_kind_sel  = fetch_req ? c_KIND_FETCH : (data_rd_req ? c_KIND_READ : c_KIND_WRITE);
    assign w_off_ext   = ADDR_W'($signed(branch_off));

    // PC next value: runs every cycle, independent of the access sequencer.
    always_comb begin
        w_pc_nxt = r_pc;
        if (clear_pc) begin
            w_pc_nxt = start_pc;
        end else begin
            case (pc_cmd)
                2'b01:   w_pc_nxt = r_pc + c_PC_ONE;
                2'b10:   w_pc_nxt = r_pc + w_off_ext;
                2'b11:   w_pc_nxt = branch_abs;
                default: w_pc_nxt = r_pc;
            endcase
        end
    end

    // Sequencer next-state, event decode and bus strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_err_nxt   = 1'b0;
        mem.mem_rd  = 1'b0;
        mem.mem_wr  = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_req_any) begin
                    w_accept    = 1'b1;
                    w_err_nxt   = w_req_multi;
                    w_state_nxt = c_ST_ACCESS;
                end
            end
            c_ST_ACCESS: begin
                mem.mem_rd = (r_kind != c_KIND_WRITE);
                mem.mem_wr = (r_kind == c_KIND_WRITE);
                w_err_nxt  = w_req_any;
                if (mem.mem_ready) begin
                    w_capture   = 1'b1;
                    w_state_nxt = c_ST_DONE;
                end else if (r_cnt == c_TIMEOUT_CNT) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = c_ST_IDLE;
                end
            end
            c_ST_DONE: begin
                w_err_nxt   = w_req_any;
                w_state_nxt = c_ST_IDLE;
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc      <= start_pc;
            r_daddr   <= '0;
            r_kind    <= c_KIND_FETCH;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_cnt     <= '0;
            r_instr   <= '0;
            r_rd_data <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_pc <= w_pc_nxt;
            if (load_addr) begin
                r_daddr <= addr_src[ADDR_W-1:0];
            end
            // Address and data are latched from pre-edge register values so
            // later PC/address updates cannot disturb the in-flight access.
            if (w_accept) begin
                r_kind  <= w_kind_sel;
                r_addr  <= fetch_req ? r_pc : r_daddr;
                r_wdata <= wr_data;
                r_cnt   <= c_CNT_ONE;
            end else if (r_state == c_ST_ACCESS && r_cnt != c_TIMEOUT_CNT) begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end
            if (w_capture && r_kind == c_KIND_FETCH) begin
                r_instr <= mem.mem_rdata;
            end
            if (w_capture && r_kind == c_KIND_READ) begin
                r_rd_data <= mem.mem_rdata;
            end
            r_done <= w_capture;
            r_err  <= w_err_nxt;
        end
    end

    assign mem.mem_addr  = r_addr;
    assign mem.mem_wdata = r_wdata;
    assign pc            = r_pc;
    assign pc_plus1      = r_pc + c_PC_ONE;
    assign instr         = r_instr;
    assign rd_data       = r_rd_data;
    assign busy          = (r_state != c_ST_IDLE);
    assign done          = r_done;
    assign err           = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Self-checking bench for mem_access_unit. A transaction-level
//               reference model predicts every output each cycle; directed
//               scenarios add fixed expected values, followed by a long
//               randomized run with a random-latency memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 16;
    localparam int OFF_W   = 8;
    localparam int TIMEOUT = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic [ADDR_W-1:0] start_pc;
    logic              clear_pc;
    logic [1:0]        pc_cmd;
    logic [OFF_W-1:0]  branch_off;
    logic [ADDR_W-1:0] branch_abs;
    logic              load_addr;
    logic [DATA_W-1:0] addr_src;
    logic              fetch_req;
    logic              data_rd_req;
    logic              data_wr_req;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus1;
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] rd_data;
    logic              busy;
    logic              done;
    logic              err;

    logic              tb_ready;
    logic [DATA_W-1:0] tb_rdata;

    mem_access_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_if ();
    assign mem_if.mem_ready = tb_ready;
    assign mem_if.mem_rdata = tb_rdata;

    mem_access_unit #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .OFF_W(OFF_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_pc(start_pc), .clear_pc(clear_pc),
        .pc_cmd(pc_cmd), .branch_off(branch_off), .branch_abs(branch_abs),
        .load_addr(load_addr), .addr_src(addr_src), .fetch_req(fetch_req),
        .data_rd_req(data_rd_req), .data_wr_req(data_wr_req), .wr_data(wr_data),
        .mem(mem_if), .pc(pc), .pc_plus1(pc_plus1), .instr(instr),
        .rd_data(rd_data), .busy(busy), .done(done), .err(err)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    logic [7:0]  m_pc, m_daddr, m_addr;
    logic [15:0] m_instr, m_rd, m_wdata;
    int          m_kind;     // 0 fetch, 1 read, 2 write
    int          m_age;      // 0 = no access in flight, else access cycle number
    bit          m_in_done;
    bit          m_done, m_err;

    task automatic model_edge();
        int nreq;
        int off;
        nreq = int'(fetch_req) + int'(data_rd_req) + int'(data_wr_req);
        if (!rst_n) begin
            m_pc = start_pc; m_daddr = 0; m_addr = 0; m_wdata = 0;
            m_instr = 0; m_rd = 0; m_kind = 0; m_age = 0;
            m_in_done = 0; m_done = 0; m_err = 0;
            return;
        end
        m_done = 0;
        m_err  = 0;
        if (m_in_done) begin
            m_in_done = 0;
            m_err = (nreq > 0);
        end else if (m_age == 0) begin
            if (nreq > 0) begin
                m_kind  = fetch_req ? 0 : (data_rd_req ? 1 : 2);
                m_addr  = fetch_req ? m_pc : m_daddr;
                m_wdata = wr_data;
                m_age   = 1;
                m_err   = (nreq > 1);
            end
        end else begin
            m_err = (nreq > 0);
            if (tb_ready) begin
                if (m_kind == 0) m_instr = tb_rdata;
                else if (m_kind == 1) m_rd = tb_rdata;
                m_age = 0; m_in_done = 1; m_done = 1;
            end else if (m_age == TIMEOUT) begin
                m_age = 0; m_err = 1;
            end else begin
                m_age++;
            end
        end
        if (clear_pc) begin
            m_pc = start_pc;
        end else if (pc_cmd == 2'b01) begin
            m_pc = 8'((int'(m_pc) + 1) % 256);
        end else if (pc_cmd == 2'b10) begin
            off  = (int'(branch_off) >= 128) ? int'(branch_off) - 256 : int'(branch_off);
            m_pc = 8'((int'(m_pc) + off + 256) % 256);
        end else if (pc_cmd == 2'b11) begin
            m_pc = branch_abs;
        end
        if (load_addr) m_daddr = addr_src[7:0];
    endtask

    task automatic compare_all();
        check_val("pc",        32'(pc),               32'(m_pc));
        check_val("pc_plus1",  32'(pc_plus1),         32'((int'(m_pc) + 1) % 256));
        check_val("mem_addr",  32'(mem_if.mem_addr),  32'(m_addr));
        check_val("mem_wdata", 32'(mem_if.mem_wdata), 32'(m_wdata));
        check_val("mem_rd",    32'(mem_if.mem_rd),    32'(m_age > 0 && m_kind != 2));
        check_val("mem_wr",    32'(mem_if.mem_wr),    32'(m_age > 0 && m_kind == 2));
        check_val("instr",     32'(instr),            32'(m_instr));
        check_val("rd_data",   32'(rd_data),          32'(m_rd));
        check_val("busy",      32'(busy),             32'(m_age > 0 || m_in_done));
        check_val("done",      32'(done),             32'(m_done));
        check_val("err",       32'(err),              32'(m_err));
    endtask

    // ---------------- memory responder for the random run ----------------
    bit auto_mem = 0;
    int rsp_age = 0;
    int rsp_target = 0;

    task automatic responder();
        tb_rdata = 16'($urandom);
        if (mem_if.mem_rd || mem_if.mem_wr) begin
            if (rsp_age == 0)
                rsp_target = ($urandom_range(0, 7) == 0) ? 40 : int'($urandom_range(0, 4));
            tb_ready = (rsp_age == rsp_target);
            rsp_age++;
        end else begin
            rsp_age  = 0;
            tb_ready = ($urandom_range(0, 1) == 1);
        end
    endtask

    task automatic tick();
        if (auto_mem) responder();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    int rd_cnt, done_at, busy_cnt, err_cnt, err_at, done_cnt;

    initial begin
        rst_n = 0; start_pc = 8'h20; clear_pc = 0; pc_cmd = 0; branch_off = 0;
        branch_abs = 0; load_addr = 0; addr_src = 0; fetch_req = 0;
        data_rd_req = 0; data_wr_req = 0; wr_data = 0; tb_ready = 0; tb_rdata = 0;

        // Reset and PC arithmetic
        tick(); tick();
        check_val("rst_pc", 32'(pc), 32'h20);
        check_val("rst_busy", 32'(busy), 32'h0);
        rst_n = 1; pc_cmd = 2'b01;
        repeat (3) tick();
        pc_cmd = 2'b00;
        check_val("pc_inc3", 32'(pc), 32'h23);
        check_val("pc_plus1_24", 32'(pc_plus1), 32'h24);
        pc_cmd = 2'b11; branch_abs = 8'hFF; tick();
        pc_cmd = 2'b01; tick();
        check_val("pc_wrap", 32'(pc), 32'h00);
        pc_cmd = 2'b11; branch_abs = 8'h10; tick();
        pc_cmd = 2'b10; branch_off = 8'hFE; tick();
        check_val("pc_rel_neg", 32'(pc), 32'h0E);
        pc_cmd = 2'b11; branch_abs = 8'h80; tick();
        check_val("pc_abs", 32'(pc), 32'h80);
        clear_pc = 1; pc_cmd = 2'b11; tick();
        clear_pc = 0; pc_cmd = 2'b00;
        check_val("pc_clear", 32'(pc), 32'h20);

        // Fetch with two wait states
        pc_cmd = 2'b11; branch_abs = 8'h05; tick();
        pc_cmd = 2'b00;
        fetch_req = 1; tick(); fetch_req = 0;
        rd_cnt = 0; done_at = 0;
        for (int c = 1; c <= 6; c++) begin
            if (mem_if.mem_rd) begin
                rd_cnt++;
                check_val("fetch_addr", 32'(mem_if.mem_addr), 32'h05);
            end
            if (done) done_at = c;
            tb_ready = (c == 3);
            tb_rdata = (c == 3) ? 16'hA5C3 : 16'h0000;
            tick();
        end
        tb_ready = 0;
        check_val("fetch_rd_cycles", 32'(rd_cnt), 32'd3);
        check_val("fetch_done_at", 32'(done_at), 32'd4);
        check_val("fetch_instr", 32'(instr), 32'hA5C3);

        // Write with immediate ready
        load_addr = 1; addr_src = 16'h1234; tick(); load_addr = 0;
        data_wr_req = 1; wr_data = 16'hBEEF; tick(); data_wr_req = 0;
        check_val("wr_strobe", 32'(mem_if.mem_wr), 32'h1);
        check_val("wr_addr", 32'(mem_if.mem_addr), 32'h34);
        check_val("wr_data", 32'(mem_if.mem_wdata), 32'hBEEF);
        tb_ready = 1; tick(); tb_ready = 0;
        check_val("wr_done", 32'(done), 32'h1);
        check_val("wr_strobe_off", 32'(mem_if.mem_wr), 32'h0);
        check_val("wr_rd_keep", 32'(rd_data), 32'h0);
        tick();

        // Dropped request and request while busy
        fetch_req = 1; data_rd_req = 1; tick(); fetch_req = 0; data_rd_req = 0;
        check_val("drop_err", 32'(err), 32'h1);
        check_val("drop_fetch_rd", 32'(mem_if.mem_rd), 32'h1);
        check_val("drop_fetch_addr", 32'(mem_if.mem_addr), 32'h05);
        data_rd_req = 1; tick(); data_rd_req = 0;
        check_val("busy_req_err", 32'(err), 32'h1);
        tb_ready = 1; tb_rdata = 16'h1111; tick(); tb_ready = 0;
        check_val("busy_req_done", 32'(done), 32'h1);
        check_val("busy_req_instr", 32'(instr), 32'h1111);
        tick(); tick();
        check_val("no_second_access", 32'(mem_if.mem_rd | busy), 32'h0);
        check_val("no_second_rd_data", 32'(rd_data), 32'h0);

        // Timeout
        fetch_req = 1; tick(); fetch_req = 0;
        busy_cnt = 0; err_cnt = 0; err_at = 0; done_cnt = 0;
        for (int c = 1; c <= 20; c++) begin
            if (busy) busy_cnt++;
            if (err) begin err_cnt++; err_at = c; end
            if (done) done_cnt++;
            tick();
        end
        check_val("to_busy_cycles", 32'(busy_cnt), 32'd15);
        check_val("to_err_count", 32'(err_cnt), 32'd1);
        check_val("to_err_at", 32'(err_at), 32'd16);
        check_val("to_no_done", 32'(done_cnt), 32'd0);
        check_val("to_instr_keep", 32'(instr), 32'h1111);

        // Reset mid-access
        fetch_req = 1; tick(); fetch_req = 0;
        tick();
        rst_n = 0; tick();
        check_val("rst_abort_rd", 32'(mem_if.mem_rd), 32'h0);
        check_val("rst_abort_done", 32'(done), 32'h0);
        check_val("rst_abort_busy", 32'(busy), 32'h0);
        rst_n = 1; tick();

        // Randomized run against the model
        auto_mem = 1;
        for (int i = 0; i < 4000; i++) begin
            rst_n       = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 49) == 0) start_pc = 8'($urandom);
            clear_pc    = ($urandom_range(0, 19) == 0);
            pc_cmd      = 2'($urandom);
            branch_off  = 8'($urandom);
            branch_abs  = 8'($urandom);
            load_addr   = ($urandom_range(0, 3) == 0);
            addr_src    = 16'($urandom);
            fetch_req   = ($urandom_range(0, 5) == 0);
            data_rd_req = ($urandom_range(0, 5) == 0);
            data_wr_req = ($urandom_range(0, 5) == 0);
            wr_data     = 16'($urandom);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
